// File: rtl/round_share_sched.sv
// Round-robin shared requantiser: NUM_CH requesters feed one round-half-up shift/saturate unit
// through a two-stage pipeline (S1 capture, S2 arithmetic + output register).
module round_share_sched #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH_IN  = 32,
    parameter int unsigned WIDTH_OUT = 16,
    parameter int unsigned SHIFT_W   = 5,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*WIDTH_IN-1:0]   req_data,
    input  logic [NUM_CH*SHIFT_W-1:0]    cfg_shift,
    input  logic                         cfg_sat_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_OUT-1:0]         out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_sat,
    output logic [15:0]                  sat_cnt,
    input  logic                         sat_clr
);

    localparam logic signed [WIDTH_IN:0] MAXV =
        {{(WIDTH_IN-WIDTH_OUT+2){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_IN:0] MINV = ~MAXV;
    localparam logic signed [WIDTH_IN:0] ONE  = {{WIDTH_IN{1'b0}}, 1'b1};

    logic [WIDTH_IN-1:0] ch_data  [NUM_CH];
    logic [SHIFT_W-1:0]  ch_shift [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ch_data[c]  = req_data[c*WIDTH_IN +: WIDTH_IN];
        assign ch_shift[c] = cfg_shift[c*SHIFT_W +: SHIFT_W];
    end

    logic [CH_W-1:0]     rr_q, rr_d, gnt;
    logic                found, adv, s1_load, accept;
    logic                s1_valid_q;
    logic [WIDTH_IN-1:0] s1_data_q;
    logic [CH_W-1:0]     s1_ch_q;
    logic [SHIFT_W-1:0]  s1_shift_q;

    assign adv     = !out_valid || out_ready;
    assign s1_load = !s1_valid_q || adv;
    assign accept  = found && s1_load && !rst;

    // Search upward from the rr pointer with wrap; first valid requester wins.
    always_comb begin
        int unsigned     idx;
        logic [CH_W-1:0] cand;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx  = (32'(rr_q) + i) % NUM_CH;
            cand = CH_W'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = (gnt == CH_W'(NUM_CH-1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            if (s1_load) s1_valid_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data_q  <= ch_data[gnt];
            s1_ch_q    <= gnt;
            s1_shift_q <= ch_shift[gnt];
        end
    end

    // One guard bit above the input keeps the rounding add from overflowing.
    int unsigned              sh;
    logic signed [WIDTH_IN:0] ext, rnd, r;
    logic [WIDTH_OUT-1:0]     q_data;
    logic                     q_sat;

    always_comb begin
        sh = 32'(s1_shift_q);
        if (sh > WIDTH_IN - 1) sh = WIDTH_IN - 1;
        ext    = {s1_data_q[WIDTH_IN-1], s1_data_q};
        rnd    = ext;
        r      = ext;
        q_data = r[WIDTH_OUT-1:0];
        q_sat  = 1'b0;
        if (sh != 0) begin
            rnd = ext + (ONE << (sh - 1));
            r   = rnd >>> sh;
        end
        if (cfg_sat_en && (r > MAXV)) begin
            q_data = MAXV[WIDTH_OUT-1:0];
            q_sat  = 1'b1;
        end else if (cfg_sat_en && (r < MINV)) begin
            q_data = MINV[WIDTH_OUT-1:0];
            q_sat  = 1'b1;
        end else begin
            q_data = r[WIDTH_OUT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_data <= q_data;
                out_ch   <= s1_ch_q;
                out_sat  <= q_sat;
            end
        end
    end

    // Clear takes priority over a same-cycle clamp event.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_cnt <= '0;
        end else if (adv && s1_valid_q && q_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_round_share_sched.sv
// Directed bench for round_share_sched: scoreboard of expected samples pushed at accept time,
// popped and compared whenever the output handshake completes.
module tb_round_share_sched;

    localparam int NCH = 4;
    localparam int WI  = 32;
    localparam int SW  = 5;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ch;
        logic        sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH*WI-1:0] req_data = '0;
    logic [NCH*SW-1:0] cfg_shift = '0;
    logic              cfg_sat_en = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_data;
    logic [1:0]        out_ch;
    logic              out_sat;
    logic [15:0]       sat_cnt;
    logic              sat_clr = 1'b0;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_g    = 0;

    always #5 clk = ~clk;

    round_share_sched #(
        .NUM_CH   (NCH),
        .WIDTH_IN (WI),
        .WIDTH_OUT(16),
        .SHIFT_W  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .cfg_shift (cfg_shift),
        .cfg_sat_en(cfg_sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input int ch, input logic [31:0] d, input logic [4:0] sh,
                                   input logic sat_en);
        exp_t   e;
        longint v, r;
        int     s;
        v = longint'($signed(d));
        s = int'(sh);
        if (s > 31) s = 31;
        if (s == 0) r = v;
        else r = (v + (longint'(1) <<< (s - 1))) >>> s;
        e.ch   = 2'(ch);
        e.sat  = 1'b0;
        e.data = r[15:0];
        if (sat_en && r > 32767) begin
            e.data = 16'h7FFF;
            e.sat  = 1'b1;
        end else if (sat_en && r < -32768) begin
            e.data = 16'h8000;
            e.sat  = 1'b1;
        end
        return e;
    endfunction

    task automatic push(input int ch);
        sb.push_back(model(ch, req_data[ch*WI +: WI], cfg_shift[ch*SW +: SW], cfg_sat_en));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra: got output ch %0d data 0x%0h, required no output",
                       out_ch, out_data);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.data));
                chk("out_ch", 32'(out_ch), 32'(mon_e.ch));
                chk("out_sat", 32'(out_sat), 32'(mon_e.sat));
            end
        end
    end

    task automatic send(input int ch, input logic [31:0] d, input logic [4:0] sh);
        bit got;
        got = 1'b0;
        req_data[ch*WI +: WI]  = d;
        cfg_shift[ch*SW +: SW] = sh;
        req_valid[ch]          = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = req_ready[ch];
        end
        chk("send_grant", 32'(req_ready), 32'(1) << ch);
        if (got) push(ch);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: %0d results pending, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1) << exp_g);
            if (k >= 2) chk("stream_out_valid", 32'(out_valid), 32'd1);
            push(exp_g);
            exp_g = (exp_g + 1) % NCH;
        end
        @(posedge clk); #1;
    endtask

    task automatic stall(input int n);
        exp_t first;
        first = model(0, 32'd0, 5'd0, 1'b0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < 2) begin
                chk("stall_grant", 32'(req_ready), 32'(1) << exp_g);
                push(exp_g);
                if (k == 0) first = sb[sb.size()-1];
                exp_g = (exp_g + 1) % NCH;
            end else begin
                chk("stall_ready", 32'(req_ready), 32'd0);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(first.data));
                chk("stall_ch", 32'(out_ch), 32'(first.ch));
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: requests must be refused while rst is high.
        req_valid = '1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(posedge clk); #1;

        // Single sample, two-cycle latency, positive tie rounds up.
        send(0, 32'h0000_0018, 5'd4);
        @(negedge clk);
        chk("lat_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_s2", 32'(out_valid), 32'd1);
        drain();

        // Negative tie rounds toward +inf; just past the tie rounds down.
        send(1, 32'hFFFF_FFD8, 5'd4);
        send(2, 32'hFFFF_FFD7, 5'd4);
        drain();

        // Saturate, then wrap with the same input.
        send(3, 32'h7FFF_FFFF, 5'd4);
        drain();
        @(negedge clk);
        chk("sat_cnt_one", 32'(sat_cnt), 32'd1);
        @(posedge clk); #1;
        cfg_sat_en = 1'b0;
        send(3, 32'h7FFF_FFFF, 5'd4);
        drain();
        @(negedge clk);
        chk("sat_cnt_wrap", 32'(sat_cnt), 32'd1);
        @(posedge clk); #1;
        cfg_sat_en = 1'b1;

        // All channels valid: strict rotation, one result per cycle, per-channel shift.
        cfg_shift = {5'd3, 5'd2, 5'd1, 5'd0};
        req_data  = {4{32'd7}};
        req_valid = '1;
        exp_g     = 0;
        stream(8);
        req_valid = '0;
        drain();

        // Backpressure from empty: two accepts then hold, release resumes in order.
        req_valid = '1;
        out_ready = 1'b0;
        stall(5);
        out_ready = 1'b1;
        stream(4);
        req_valid = '0;
        drain();

        // Clear in the same cycle as a clamp event.
        @(negedge clk);
        chk("sat_cnt_pre_clr", 32'(sat_cnt), 32'd1);
        @(posedge clk); #1;
        req_data[31:0] = 32'h7FFF_FFFF;
        cfg_shift[4:0] = 5'd4;
        req_valid      = 4'b0001;
        @(negedge clk);
        chk("clr_grant", 32'(req_ready), 32'd1);
        push(0);
        @(posedge clk); #1;
        req_valid = '0;
        sat_clr   = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        @(negedge clk);
        chk("sat_cnt_clr_wins", 32'(sat_cnt), 32'd0);
        @(posedge clk); #1;

        // Reset with both stages full: in-flight samples vanish, rr restarts at ch0.
        req_data  = {4{32'h7FFF_FFFF}};
        cfg_shift = {4{5'd4}};
        req_valid = '1;
        out_ready = 1'b0;
        exp_g     = 1;
        stall(2);
        @(negedge clk);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_sat_cnt", 32'(sat_cnt), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("midrst_first_grant", 32'(req_ready), 32'd1);
        push(0);
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("post_rst_sat_cnt", 32'(sat_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
